keypad_time_entry: RTL and testbench

//  Upstream stage of the microwave timer. Captures keypad digit presses into a
//  3-digit BCD M:SS buffer, validates the value, and issues a one-cycle

---
 rtl/keypad_time_entry.sv | 164 ++++++++++++++++
 tb/tb_keypad_time_entry.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_time_entry.sv
// keypad_time_entry: captures keypad digits into a 3-digit BCD M:SS buffer,
// validates seconds-tens on start, and issues a one-cycle active-low load
// strobe with parallel BCD data to the down-counter chain.
// Optional feature: define KEYPAD_TIME_ENTRY_BEEP_EN to add the beep output.
module keypad_time_entry #(
  parameter int unsigned BEEP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start_key,
  input  logic       stop_key,
  input  logic       timer_done,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic       loadn,
  output logic       busy,
  output logic       err,
`ifdef KEYPAD_TIME_ENTRY_BEEP_EN
  output logic       beep,
`endif
  output logic [1:0] digit_cnt
);

  typedef enum logic [1:0] {IDLE, ENTRY, LOAD, LOCKED} state_t;

  state_t     state, state_n;
  logic       kv_r, kv_p, st_r, st_p, sp_r, sp_p;
  logic [3:0] kc_r;
  logic       lk_arm;
  logic       kv_ev, start_ev, stop_ev, dig_ev;
  logic [3:0] so_n, st_n, mo_n;
  logic [1:0] cnt_n;
  logic       err_n;
  logic       beep_trig;

  if (BEEP_CYCLES < 1) begin : g_beep_cycles_check
    $error("BEEP_CYCLES must be at least 1");
  end

  // Rising-edge events are taken between the input register and its delayed copy,
  // so key_code is registered alongside key_valid to stay aligned with the event.
  assign kv_ev    = kv_r & ~kv_p;
  assign start_ev = st_r & ~st_p;
  assign stop_ev  = sp_r & ~sp_p;
  assign dig_ev   = kv_ev && (kc_r <= 4'd9);

  // Input register and edge-detect history
  always_ff @(posedge clk) begin
    if (clear) begin
      kv_r <= 1'b0; kv_p <= 1'b0;
      st_r <= 1'b0; st_p <= 1'b0;
      sp_r <= 1'b0; sp_p <= 1'b0;
      kc_r <= '0;
    end else begin
      kv_r <= key_valid;  kv_p <= kv_r;
      st_r <= start_key;  st_p <= st_r;
      sp_r <= stop_key;   sp_p <= sp_r;
      kc_r <= key_code;
    end
  end

  // Next-state, digit buffer and pulse decode; stop > start > digit priority
  always_comb begin
    state_n   = state;
    so_n      = sec_ones;
    st_n      = sec_tens;
    mo_n      = min_ones;
    cnt_n     = digit_cnt;
    err_n     = 1'b0;
    beep_trig = 1'b0;
    case (state)
      IDLE: begin
        if (dig_ev && !start_ev && !stop_ev) begin
          mo_n      = sec_tens;
          st_n      = sec_ones;
          so_n      = kc_r;
          cnt_n     = 2'd1;
          beep_trig = 1'b1;
          state_n   = ENTRY;
        end
      end
      ENTRY: begin
        if (stop_ev) begin
          so_n = '0; st_n = '0; mo_n = '0; cnt_n = '0;
          state_n = IDLE;
        end else if (start_ev) begin
          beep_trig = 1'b1;
          if (sec_tens <= 4'd5) begin
            state_n = LOAD;
          end else begin
            err_n = 1'b1;
            so_n = '0; st_n = '0; mo_n = '0; cnt_n = '0;
            state_n = IDLE;
          end
        end else if (dig_ev) begin
          mo_n      = sec_tens;
          st_n      = sec_ones;
          so_n      = kc_r;
          cnt_n     = (digit_cnt == 2'd3) ? 2'd3 : digit_cnt + 2'd1;
          beep_trig = 1'b1;
        end
      end
      LOAD: begin
        so_n = '0; st_n = '0; mo_n = '0; cnt_n = '0;
        state_n = LOCKED;
      end
      LOCKED: begin
        if (stop_ev || (lk_arm && timer_done)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, digit buffer and registered outputs derived from the next state
  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= IDLE;
      sec_ones  <= '0;
      sec_tens  <= '0;
      min_ones  <= '0;
      digit_cnt <= '0;
      loadn     <= 1'b1;
      busy      <= 1'b0;
      err       <= 1'b0;
      lk_arm    <= 1'b0;
    end else begin
      state     <= state_n;
      sec_ones  <= so_n;
      sec_tens  <= st_n;
      min_ones  <= mo_n;
      digit_cnt <= cnt_n;
      loadn     <= (state_n != LOAD);
      busy      <= (state_n == LOCKED);
      err       <= err_n;
      // Set after the first LOCKED cycle so timer_done is ignored until then
      lk_arm    <= (state == LOCKED);
    end
  end

`ifdef KEYPAD_TIME_ENTRY_BEEP_EN
  localparam int unsigned BW = $clog2(BEEP_CYCLES + 1);
  logic [BW-1:0] beep_cnt;

  // Beep duration counter, restarted by every trigger
  always_ff @(posedge clk) begin
    if (clear) begin
      beep_cnt <= '0;
    end else if (beep_trig) begin
      beep_cnt <= BW'(BEEP_CYCLES);
    end else if (beep_cnt != '0) begin
      beep_cnt <= beep_cnt - 1'b1;
    end
  end

  assign beep = (beep_cnt != '0);
`else
  logic unused_beep_trig;
  assign unused_beep_trig = beep_trig;
`endif

endmodule

// File: tb/tb_keypad_time_entry.sv
// Scoreboard bench for keypad_time_entry: load/err pulses are checked by a
// monitor against a queue of expected responses; static state is checked inline.
module tb_keypad_time_entry;

  logic       clk = 1'b0;
  logic       clear;
  logic       key_valid;
  logic [3:0] key_code;
  logic       start_key;
  logic       stop_key;
  logic       timer_done;
  logic [3:0] sec_ones, sec_tens, min_ones;
  logic       loadn, busy, err;
  logic [1:0] digit_cnt;
`ifdef KEYPAD_TIME_ENTRY_BEEP_EN
  logic       beep;
`endif

  typedef struct {
    bit         is_err;
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] o;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  keypad_time_entry #(.BEEP_CYCLES(4)) dut (
    .clk(clk), .clear(clear), .key_valid(key_valid), .key_code(key_code),
    .start_key(start_key), .stop_key(stop_key), .timer_done(timer_done),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
    .loadn(loadn), .busy(busy), .err(err),
`ifdef KEYPAD_TIME_ENTRY_BEEP_EN
    .beep(beep),
`endif
    .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] code);
    key_valid = 1'b1; key_code = code;
    ticks(2);
    key_valid = 1'b0;
    ticks(2);
  endtask

  task automatic push_load(input logic [3:0] m, input logic [3:0] t, input logic [3:0] o);
    exp_t e;
    e.is_err = 1'b0; e.m = m; e.t = t; e.o = o;
    q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.m = '0; e.t = '0; e.o = '0;
    q.push_back(e);
  endtask

  task automatic do_start();
    start_key = 1'b1; tick();
    start_key = 1'b0; ticks(3);
  endtask

  task automatic do_stop();
    stop_key = 1'b1; tick();
    stop_key = 1'b0; ticks(3);
  endtask

  task automatic chk_digits(input string name, input int m, input int t, input int o, input int c);
    chk({name, "_min_ones"}, int'(min_ones), m);
    chk({name, "_sec_tens"}, int'(sec_tens), t);
    chk({name, "_sec_ones"}, int'(sec_ones), o);
    chk({name, "_digit_cnt"}, int'(digit_cnt), c);
  endtask

  // Monitor: every load strobe or err pulse must match the next queued expectation
  always @(negedge clk) begin
    if (loadn === 1'b0 || err === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got loadn=%b err=%b data=%0d%0d%0d expected no pulse",
                 loadn, err, min_ones, sec_tens, sec_ones);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.is_err) begin
          if (!(err === 1'b1 && loadn === 1'b1)) begin
            errors++;
            $display("FAIL err_pulse: got err=%b loadn=%b expected err=1 loadn=1", err, loadn);
          end
        end else if (!(loadn === 1'b0 && err === 1'b0 && min_ones === e.m &&
                       sec_tens === e.t && sec_ones === e.o)) begin
          errors++;
          $display("FAIL load_pulse: got loadn=%b err=%b data=%0d:%0d%0d expected loadn=0 data=%0d:%0d%0d",
                   loadn, err, min_ones, sec_tens, sec_ones, e.m, e.t, e.o);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1; key_valid = 1'b0; key_code = '0;
    start_key = 1'b0; stop_key = 1'b0; timer_done = 1'b0;
    ticks(3);
    clear = 1'b0;
    tick();
    chk("reset_loadn", int'(loadn), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_err", int'(err), 0);
    chk_digits("reset", 0, 0, 0, 0);

    // Start in IDLE is ignored (monitor flags any pulse)
    do_start();
    chk("idle_start_busy", int'(busy), 0);

    // 1: 1,3,0 then start -> load 1:30, then locked with cleared digits
    press(4'd1); press(4'd3); press(4'd0);
    chk_digits("t1_entry", 1, 3, 0, 3);
    push_load(4'd1, 4'd3, 4'd0);
    do_start();
    chk("t1_busy", int'(busy), 1);
    chk_digits("t1_locked", 0, 0, 0, 0);
    do_stop();
    chk("t1_stop_busy", int'(busy), 0);

    // 2: four digits drop the oldest; stop clears
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    chk_digits("t2", 2, 3, 4, 3);
    do_stop();
    chk_digits("t2_stop", 0, 0, 0, 0);

    // 3: seconds-tens 7 rejected
    press(4'd1); press(4'd7); press(4'd5);
    push_err();
    do_start();
    chk("t3_busy", int'(busy), 0);
    chk_digits("t3", 0, 0, 0, 0);

    // 4: held key gives one digit; code 12 ignored
    key_valid = 1'b1; key_code = 4'd5;
    ticks(20);
    key_valid = 1'b0; ticks(2);
    press(4'd12);
    chk_digits("t4", 0, 0, 5, 1);
    do_stop();

    // 5: seconds-tens 5 accepted; locked ignores digits/start; timer_done releases
    press(4'd1); press(4'd5); press(4'd9);
    push_load(4'd1, 4'd5, 4'd9);
    do_start();
    chk("t5_busy", int'(busy), 1);
    press(4'd9);
    do_start();
    chk("t5_locked_busy", int'(busy), 1);
    chk_digits("t5_locked", 0, 0, 0, 0);
    timer_done = 1'b1;
    tick();
    chk("t5_done_busy", int'(busy), 0);
    timer_done = 1'b0;
    ticks(2);

    // timer_done held high while entering LOCKED: first LOCKED cycle ignores it
    press(4'd2);
    push_load(4'd0, 4'd0, 4'd2);
    timer_done = 1'b1;
    start_key = 1'b1; tick();
    start_key = 1'b0; tick();
    chk("td_load_cycle_loadn", int'(loadn), 0);
    tick();
    chk("td_locked1_busy", int'(busy), 1);
    tick();
    chk("td_locked2_busy", int'(busy), 1);
    tick();
    chk("td_release_busy", int'(busy), 0);
    timer_done = 1'b0;
    ticks(2);

    // 6: clear during the LOAD cycle
    press(4'd4); press(4'd5);
    push_load(4'd0, 4'd4, 4'd5);
    start_key = 1'b1; tick();
    start_key = 1'b0; tick();
    chk("t6_load_cycle_loadn", int'(loadn), 0);
    clear = 1'b1; tick();
    clear = 1'b0;
    chk("t6_loadn", int'(loadn), 1);
    chk("t6_busy", int'(busy), 0);
    chk("t6_err", int'(err), 0);
    chk_digits("t6", 0, 0, 0, 0);
    ticks(3);
    chk("t6_idle_busy", int'(busy), 0);

    // Start and digit together: digit dropped, load proceeds with 0:03
    press(4'd3);
    push_load(4'd0, 4'd0, 4'd3);
    key_valid = 1'b1; key_code = 4'd7; start_key = 1'b1;
    tick();
    key_valid = 1'b0; start_key = 1'b0;
    ticks(3);
    chk("t6b_busy", int'(busy), 1);
    do_stop();

    ticks(3);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
